softmax_seq_ctrl: RTL
=====================

Name: softmax_seq_ctrl

Overview:
Sequencing controller for the classifier output stage. The fully connected layer streams its HEIGHT class scores serially, one per beat, over a valid/ready handshake. This block tracks a running signed maximum and its index, then presents the predicted digit on a valid/ready result port. It replaces the flat HEIGHT-wide score bus with a serial interface and owns the start, collect and deliver sequencing for one inference.

Parameters:
BITS, 24, bit depth of each score and of predict_num
HEIGHT, 10, number of class scores per inference (HEIGHT >= 2)
CNT_W, $clog2(HEIGHT), width of the internal beat counter

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state and outputs
start  input  1  begin a new inference; sampled only in IDLE
abort  input  1  synchronous; returns the block to IDLE from any state
in_valid  input  1  score beat valid
in_data  input  BITS  score, two's complement signed
in_ready  output  1  block accepts a score beat
busy  output  1  high in COLLECT and DONE
out_valid  output  1  prediction valid
out_ready  input  1  consumer accepts the prediction
predict_num  output  BITS  index of the maximum score, zero-extended
max_value  output  BITS  maximum score value

Behaviour:
- States: IDLE, COLLECT, DONE.
- Reset values: state = IDLE, counter = 0, in_ready = 0, busy = 0, out_valid = 0, predict_num = 0, max_value = 0.
- IDLE:
  - start = 1 moves to COLLECT next cycle and clears the counter.
  - predict_num and max_value hold the last result.
- COLLECT:
  - in_ready = 1 combinationally from the state.
  - A beat is accepted when in_valid & in_ready.
  - Beat 0: max_value <= in_data, predict_num <= 0.
  - Beat k > 0: if signed(in_data) > signed(max_value), then max_value <= in_data and predict_num <= k. Otherwise both hold.
  - Comparison is strict, so ties keep the lower index.
  - After each accepted beat the counter increments.
  - When the beat with counter = HEIGHT-1 is accepted, the state moves to DONE next cycle and the counter does not wrap.
  - Bubbles (in_valid = 0) stall without side effects, and there is no timeout.
- DONE:
  - out_valid = 1 and in_ready = 0.
  - predict_num and max_value are stable while out_valid = 1 and out_ready = 0.
  - out_valid & out_ready moves to IDLE next cycle, with out_valid = 0 there.
- Latency: out_valid rises 1 cycle after the last beat handshake. Minimum inference length is 1 (start) + HEIGHT beats + 1 cycle, then the DONE handshake.
- start outside IDLE is ignored, including start in the same cycle DONE exits. The next inference needs start in IDLE.
- abort has priority over every other input:
  - Next state is IDLE, counter cleared, out_valid = 0.
  - predict_num and max_value are not updated by a beat in the abort cycle.
  - abort in IDLE is a no-op.
- Asynchronous reset mid-COLLECT or mid-DONE immediately forces the reset values. A partial inference is discarded.
- No arithmetic beyond the signed compare and counter increment. Scores are never modified.

Test Plan:
1. Reset, start, scores 5,-3,9,2,9,0,1,7,-8,4 with in_valid held high -> in_ready high for exactly 10 cycles; out_valid 1 cycle after the last beat; predict_num = 2 (tie at index 4 loses); max_value = 9.
2. All scores negative, 0xFFFFF6 (-10) at index 0 and 0xFFFFFF (-1) at index 7, others -20 -> predict_num = 7, max_value = 0xFFFFFF. This confirms the compare is signed, not unsigned.
3. Same stream as test 1 with in_valid deasserted for 3 random cycles, and out_ready held low for 5 cycles in DONE -> identical result; outputs stable while stalled; state returns to IDLE 1 cycle after out_ready = 1.
4. abort asserted on the 6th beat, together with in_valid = 1 and in_data = 100 -> IDLE next cycle, out_valid never asserted; the next full inference using test 1's stream yields predict_num = 2 with no leftover state.
5. Async reset asserted mid-COLLECT, between clock edges -> in_ready, busy, out_valid and predict_num go to 0 immediately; start while busy is ignored, with no counter reset.
6. Maximum at the last index (scores 0..8 then 0x7FFFFF) -> predict_num = 9 and max_value = 0x7FFFFF. Two back-to-back inferences separated only by a start in IDLE both produce correct results.

Source files
------------

// File: rtl/softmax_seq_ctrl_if.sv
// Serial score / prediction bus for the classifier output stage.
// The master side feeds control, score beats and the result acknowledge.
// The slave side (the sequencer) returns ready, status and the prediction.
interface softmax_seq_ctrl_if #(
  parameter int BITS = 24
);
  logic            start;
  logic            abort;
  logic            in_valid;
  logic [BITS-1:0] in_data;
  logic            in_ready;
  logic            busy;
  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] predict_num;
  logic [BITS-1:0] max_value;

  modport master (
    output start, abort, in_valid, in_data, out_ready,
    input  in_ready, busy, out_valid, predict_num, max_value
  );

  modport slave (
    input  start, abort, in_valid, in_data, out_ready,
    output in_ready, busy, out_valid, predict_num, max_value
  );
endinterface

// File: rtl/softmax_seq_ctrl.sv
// Classifier output sequencer: collects HEIGHT serial signed scores, tracks
// the running maximum and its index, and hands the predicted class over a
// valid/ready result port. Ties keep the lower index.
module softmax_seq_ctrl #(
  parameter int BITS   = 24,
  parameter int HEIGHT = 10,
  parameter int CNT_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic             clk,
  input  logic             reset,
  softmax_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic signed [BITS-1:0]  max_value;
  logic [BITS-1:0]         predict_num;
  logic                    beat;
  logic                    last_beat;
  logic                    first_beat;

  // Strict signed compare: equal scores never displace the earlier index.
  function automatic logic score_gt(input logic signed [BITS-1:0] a,
                                    input logic signed [BITS-1:0] b);
    return a > b;
  endfunction

  // Handshake and status are decoded straight from the state register,
  // so an asynchronous reset clears them without waiting for a clock.
  assign bus.in_ready    = (state == COLLECT);
  assign bus.busy        = (state != IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.predict_num = predict_num;
  assign bus.max_value   = max_value;

  // A beat in an abort cycle is dropped entirely.
  assign beat       = bus.in_valid & (state == COLLECT) & ~bus.abort;
  assign last_beat  = beat & (cnt == CNT_W'(HEIGHT - 1));
  assign first_beat = (cnt == '0);

  // Next-state decode; abort overrides every other input.
  always_comb begin
    state_nxt = state;
    if (bus.abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start)     state_nxt = COLLECT;
        COLLECT: if (last_beat)     state_nxt = DONE;
        DONE:    if (bus.out_ready) state_nxt = IDLE;
        default:                    state_nxt = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Beat counter: cleared on start or abort, stops at the last index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (bus.abort) begin
      cnt <= '0;
    end else if ((state == IDLE) && bus.start) begin
      cnt <= '0;
    end else if (beat && !last_beat) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Running maximum and its index; held outside COLLECT so the last result
  // remains readable in DONE and IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_value   <= '0;
      predict_num <= '0;
    end else if (beat) begin
      if (first_beat || score_gt(bus.in_data, max_value)) begin
        max_value   <= bus.in_data;
        predict_num <= BITS'(cnt);
      end
    end
  end

endmodule
